// File: rtl/maze_tile_renderer.sv
// maze_tile_renderer: two-stage raster-to-RGB444 renderer for the welcome/maze/win/pause screens
// Optional build macro MAZE_GRID_LINES_EN draws 12'h444 on the first pixel row/column of every tile.
// Ports: vga_clk_i/rst_sys_n_i clock and async active-low reset; state_i screen select;
//   x_i/y_i/de_i raster position and active-video; frame_start_i geometry latch pulse;
//   num_i tiles per side; map_i walls, trail_i visited tiles (bit ty*num+tx);
//   cur/start/end_{x,y}_i special tiles; pix_data_o RGB444, pix_de_o aligned de,
//   tile_x_o/tile_y_o tile under pix_data_o (31 outside the maze).
module maze_tile_renderer #(
  parameter int H_VALID    = 640,
  parameter int V_VALID    = 480,
  parameter int BLOCK_W    = 24,
  parameter int MAX_N      = 19,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                     vga_clk_i,
  input  logic                     rst_sys_n_i,
  input  logic [1:0]               state_i,
  input  logic [X_W-1:0]           x_i,
  input  logic [Y_W-1:0]           y_i,
  input  logic                     de_i,
  input  logic                     frame_start_i,
  input  logic [4:0]               num_i,
  input  logic [MAX_N*MAX_N-1:0]   map_i,
  input  logic [MAX_N*MAX_N-1:0]   trail_i,
  input  logic [4:0]               cur_x_i,
  input  logic [4:0]               cur_y_i,
  input  logic [4:0]               start_x_i,
  input  logic [4:0]               start_y_i,
  input  logic [4:0]               end_x_i,
  input  logic [4:0]               end_y_i,
  output logic [11:0]              pix_data_o,
  output logic                     pix_de_o,
  output logic [4:0]               tile_x_o,
  output logic [4:0]               tile_y_o
);
  localparam int NN = MAX_N * MAX_N;
  localparam int IW = $clog2(NN);
  localparam int SW = $clog2(BLOCK_W);
  localparam logic [SW-1:0] SMAX = SW'(BLOCK_W - 1);
  localparam logic [4:0] NMAX = 5'(MAX_N);
  localparam logic [X_W+3:0] HX = (X_W+4)'(H_VALID / 2);
  localparam logic [Y_W+3:0] HY = (Y_W+4)'(V_VALID / 2);
  localparam logic [11:0] WHITE = 12'hFFF, YELLOW = 12'hFF0, RED = 12'hF00, GREEN = 12'h0F0;
  localparam logic [11:0] GRAY = 12'hDDD, BLUE = 12'h00F, BLACK = 12'h000;
  logic [4:0] n_q, n_eff;
  logic [X_W-1:0] bx_q;
  logic [Y_W-1:0] by_q;
  logic [BLINK_LOG2-1:0] blink_q;
  logic [15:0] span;
  logic [X_W+3:0] bx_w;
  logic [Y_W+3:0] by_w;
  assign n_eff = num_i > NMAX ? NMAX : num_i;
  assign span = 16'(BLOCK_W) * {11'd0, n_eff};
  assign bx_w = HX - (X_W+4)'(span >> 1);
  assign by_w = HY - (Y_W+4)'(span >> 1);
  always_ff @(posedge vga_clk_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      n_q     <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      blink_q <= '0;
    end else if (frame_start_i) begin
      n_q     <= n_eff;
      bx_q    <= bx_w[X_W-1:0];
      by_q    <= by_w[Y_W-1:0];
      blink_q <= blink_q + BLINK_LOG2'(1);
    end
  end
  // Stage 1: the tracking registers double as the pipeline registers of the
  // pixel just sampled, so tile counters step with the raster instead of dividing.
  logic inx_q, inx_d, iny_q, iny_d;
  logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [4:0] tx_q, tx_d, ty_q, ty_d;
  logic x_wrap, y_wrap, line_start;
  logic [9:0] idx_full;
  assign x_wrap = sx_q == SMAX;
  assign y_wrap = sy_q == SMAX;
  assign line_start = de_i && x_i == '0;
  always_comb begin
    inx_d = inx_q;
    sx_d  = sx_q;
    tx_d  = tx_q;
    if (de_i && x_i == bx_q) begin
      inx_d = 1'b1;
      sx_d  = '0;
      tx_d  = '0;
    end else if (de_i && inx_q) begin
      inx_d = !(x_wrap && tx_q == n_q - 5'd1);
      sx_d  = x_wrap ? '0 : sx_q + SW'(1);
      tx_d  = x_wrap ? tx_q + 5'd1 : tx_q;
    end
  end
  always_comb begin
    iny_d = iny_q;
    sy_d  = sy_q;
    ty_d  = ty_q;
    if (line_start && y_i == by_q) begin
      iny_d = 1'b1;
      sy_d  = '0;
      ty_d  = '0;
    end else if (line_start && iny_q) begin
      iny_d = !(y_wrap && ty_q == n_q - 5'd1);
      sy_d  = y_wrap ? '0 : sy_q + SW'(1);
      ty_d  = y_wrap ? ty_q + 5'd1 : ty_q;
    end
  end
  assign idx_full = {5'd0, ty_d} * {5'd0, n_q} + {5'd0, tx_d};
  logic de1_q, ins1_q, idx_ok_q;
  logic [1:0] st1_q;
  logic [IW-1:0] idx_q;
`ifdef MAZE_GRID_LINES_EN
  logic edge_q;
  always_ff @(posedge vga_clk_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) edge_q <= 1'b0;
    else edge_q <= sx_d == '0 || sy_d == '0;
  end
`endif
  always_ff @(posedge vga_clk_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      {inx_q, iny_q, sx_q, sy_q, tx_q, ty_q} <= '0;
      {de1_q, ins1_q, idx_ok_q, st1_q, idx_q} <= '0;
    end else begin
      inx_q    <= inx_d;
      iny_q    <= iny_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      de1_q    <= de_i;
      st1_q    <= state_i;
      ins1_q   <= de_i && inx_d && iny_d && n_q >= 5'd3;
      idx_q    <= idx_full[IW-1:0];
      idx_ok_q <= idx_full < 10'(NN);
    end
  end
  // Stage 2: colour select
  logic wall, trl, is_cur;
  logic [11:0] base_c, maze_c, sel_c, pix_d;
  assign wall   = idx_ok_q && map_i[idx_q];
  assign trl    = idx_ok_q && trail_i[idx_q];
  assign is_cur = tx_q == cur_x_i && ty_q == cur_y_i;
  always_comb begin
    base_c = tx_q == start_x_i && ty_q == start_y_i ? GREEN :
             tx_q == end_x_i && ty_q == end_y_i ? YELLOW :
             wall ? GRAY : trl ? BLUE : BLACK;
`ifdef MAZE_GRID_LINES_EN
    base_c = edge_q ? 12'h444 : base_c;
`endif
    // paused screens hold the cursor steady instead of blinking
    maze_c = is_cur && (st1_q == 2'd3 || !blink_q[BLINK_LOG2-1]) ? RED : base_c;
    sel_c  = ins1_q ? maze_c : WHITE;
    sel_c  = st1_q == 2'd3 ? {1'b0, sel_c[11:9], 1'b0, sel_c[7:5], 1'b0, sel_c[3:1]} : sel_c;
    pix_d  = !de1_q ? BLACK : st1_q == 2'd0 ? YELLOW : st1_q == 2'd2 ? RED : sel_c;
  end
  always_ff @(posedge vga_clk_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      pix_data_o <= WHITE;
      pix_de_o   <= 1'b0;
      tile_x_o   <= 5'd31;
      tile_y_o   <= 5'd31;
    end else begin
      pix_data_o <= pix_d;
      pix_de_o   <= de1_q;
      tile_x_o   <= ins1_q ? tx_q : 5'd31;
      tile_y_o   <= ins1_q ? ty_q : 5'd31;
    end
  end
endmodule

// File: tb/tb_maze_tile_renderer.sv
// tb_maze_tile_renderer: directed raster frames with a queue-based scoreboard for maze_tile_renderer
module tb_maze_tile_renderer;
  localparam logic [11:0] WH = 12'hFFF, YE = 12'hFF0, RD = 12'hF00, GR = 12'h0F0;
  localparam logic [11:0] GY = 12'hDDD, BL = 12'h00F, BK = 12'h000;
`ifdef MAZE_GRID_LINES_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif
  typedef struct packed {logic [11:0] p; logic [4:0] tx; logic [4:0] ty;} exp_t;
  typedef struct {bit chk; exp_t e; int cyc; int x; int y;} ent_t;
  logic clk = 1'b0, rst_n;
  logic [1:0] state;
  logic [9:0] x;
  logic [8:0] y;
  logic de, fs;
  logic [4:0] num, cx, cy, sx, sy, ex, ey;
  logic [360:0] map, trail;
  logic [11:0] pix;
  logic pde;
  logic [4:0] ptx, pty;
  int cyc = 0, fcnt = 0, nvec = 0, nerr = 0;
  ent_t sb[$];
  ent_t me;
  exp_t want[int];
  int lastx[int];
  maze_tile_renderer dut (
    .vga_clk_i(clk), .rst_sys_n_i(rst_n), .state_i(state), .x_i(x), .y_i(y),
    .de_i(de), .frame_start_i(fs), .num_i(num), .map_i(map), .trail_i(trail),
    .cur_x_i(cx), .cur_y_i(cy), .start_x_i(sx), .start_y_i(sy), .end_x_i(ex), .end_y_i(ey),
    .pix_data_o(pix), .pix_de_o(pde), .tile_x_o(ptx), .tile_y_o(pty)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [11:0] gl(input logic [11:0] c);
    return GRID ? 12'h444 : c;
  endfunction
  function automatic logic [11:0] cur_col(input int f);
    return (f % 32) < 16 ? RD : YE;
  endfunction
  task automatic add(input int xx, input int yy, input logic [11:0] p, input int tx, input int ty);
    want[yy * 1024 + xx] = '{p, 5'(tx), 5'(ty)};
  endtask
  task automatic drive(input int xx, input int yy, input bit dd, input bit ff);
    @(posedge clk);
    #1;
    x = 10'(xx);
    y = 9'(yy);
    de = dd;
    fs = ff;
    if (dd) begin
      ent_t e;
      e.chk = want.exists(yy * 1024 + xx);
      e.e = e.chk ? want[yy * 1024 + xx] : '0;
      e.cyc = cyc;
      e.x = xx;
      e.y = yy;
      sb.push_back(e);
    end
  endtask
  task automatic run_frame(input int ymax, input int nmid);
    drive(0, 0, 0, 1);
    fcnt++;
    drive(0, 0, 0, 0);
    if (nmid >= 0) num = 5'(nmid);
    for (int yy = 0; yy <= ymax; yy++) begin
      for (int xx = 0; xx <= (lastx.exists(yy) ? lastx[yy] : 0); xx++) drive(xx, yy, 1, 0);
      drive(0, yy, 0, 0);
    end
    repeat (3) drive(0, 0, 0, 0);
    want.delete();
    lastx.delete();
  endtask
  task automatic dcheck(input string nm, input logic [11:0] p, input logic d, input logic [4:0] tx, input logic [4:0] ty);
    nvec++;
    if (pix !== p || pde !== d || ptx !== tx || pty !== ty) begin
      nerr++;
      $display("FAIL %s: got pix=%h de=%b tile=(%0d,%0d), required pix=%h de=%b tile=(%0d,%0d)",
               nm, pix, pde, ptx, pty, p, d, tx, ty);
    end
  endtask
  task automatic maze5();
    num = 5;
    map = '0;
    for (int i = 0; i < 25; i++) map[i] = 1'b1;
    map[6] = 1'b0;
    map[7] = 1'b0;
    trail = '0;
    trail[7] = 1'b1;
    sx = 1; sy = 1; ex = 3; ey = 3; cx = 3; cy = 3;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && pde) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL spurious: got pix_de=1 pix=%h, required no pending pixel", pix);
        end else begin
          me = sb.pop_front();
          if (me.chk) begin
            nvec++;
            if (pix !== me.e.p || ptx !== me.e.tx || pty !== me.e.ty || cyc - me.cyc != 2) begin
              nerr++;
              $display("FAIL px(%0d,%0d): got pix=%h tile=(%0d,%0d) lat=%0d, required pix=%h tile=(%0d,%0d) lat=2",
                       me.x, me.y, pix, ptx, pty, cyc - me.cyc, me.e.p, me.e.tx, me.e.ty);
            end
          end
        end
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1);
  end
  initial begin
    rst_n = 0; state = 1; x = 0; y = 0; de = 0; fs = 0; num = 19;
    map = '0; trail = '0; cx = 31; cy = 31; sx = 31; sy = 31; ex = 31; ey = 31;
    repeat (3) @(posedge clk);
    #1 dcheck("reset", WH, 1'b0, 5'd31, 5'd31);
    rst_n = 1;
    add(92, 11, WH, 31, 31);
    add(91, 12, WH, 31, 31);
    add(92, 12, gl(BK), 0, 0);
    add(547, 12, gl(BK), 18, 0);
    add(548, 12, WH, 31, 31);
    lastx[11] = 549; lastx[12] = 549;
    run_frame(12, -1);
    @(negedge clk);
    dcheck("blank", BK, 1'b0, 5'd31, 5'd31);
    num = 25;
    add(97, 17, BK, 0, 0);
    add(547, 17, BK, 18, 0);
    add(548, 17, WH, 31, 31);
    lastx[17] = 549;
    run_frame(17, -1);
    maze5();
    add(259, 209, WH, 31, 31);
    add(260, 209, gl(GY), 0, 1);
    add(265, 209, GY, 0, 1);
    add(289, 209, GR, 1, 1);
    add(313, 209, BL, 2, 1);
    add(337, 252, cur_col(fcnt + 1), 3, 3);
    add(361, 252, gl(GY), 4, 3);
    add(337, 257, cur_col(fcnt + 1), 3, 3);
    add(361, 257, GY, 4, 3);
    add(379, 257, GY, 4, 3);
    add(380, 257, WH, 31, 31);
    lastx[209] = 385; lastx[252] = 385; lastx[257] = 385;
    run_frame(257, -1);
    while (fcnt < 15) run_frame(-1, -1);
    add(337, 257, cur_col(fcnt + 1), 3, 3);
    lastx[257] = 385;
    run_frame(257, -1);
    state = 3;
    add(259, 209, 12'h777, 31, 31);
    add(265, 209, 12'h666, 0, 1);
    add(289, 209, 12'h070, 1, 1);
    add(313, 209, 12'h007, 2, 1);
    add(337, 257, 12'h700, 3, 3);
    add(361, 257, 12'h666, 4, 3);
    lastx[209] = 385; lastx[257] = 385;
    run_frame(257, -1);
    state = 1;
    while (fcnt < 31) run_frame(-1, -1);
    add(337, 257, cur_col(fcnt + 1), 3, 3);
    lastx[257] = 385;
    run_frame(257, -1);
    state = 0;
    add(0, 0, YE, 31, 31);
    add(337, 257, YE, 3, 3);
    lastx[257] = 385;
    run_frame(257, -1);
    state = 2;
    add(313, 209, RD, 2, 1);
    lastx[209] = 385;
    run_frame(209, -1);
    state = 1;
    map = '0; trail = '0; cx = 31; cy = 31; sx = 31; sy = 31; ex = 31; ey = 31;
    num = 9;
    add(140, 137, WH, 31, 31);
    add(217, 137, BK, 0, 0);
    lastx[137] = 430;
    run_frame(137, 15);
    add(139, 65, WH, 31, 31);
    add(145, 65, BK, 0, 0);
    add(217, 137, BK, 3, 3);
    lastx[65] = 505; lastx[137] = 505;
    run_frame(137, -1);
    num = 2;
    add(300, 240, WH, 31, 31);
    lastx[240] = 340;
    run_frame(240, -1);
    num = 3; cx = 3; cy = 0;
    add(283, 209, WH, 31, 31);
    add(289, 209, BK, 0, 0);
    add(355, 209, BK, 2, 0);
    add(356, 209, WH, 31, 31);
    lastx[209] = 360;
    run_frame(209, -1);
    maze5();
    state = 1;
    run_frame(208, -1);
    for (int xx = 0; xx <= 300; xx++) drive(xx, 209, 1, 0);
    #1 rst_n = 0;
    #1 dcheck("reset_mid", WH, 1'b0, 5'd31, 5'd31);
    sb.delete();
    fcnt = 0;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    rst_n = 1;
    add(0, 0, WH, 31, 31);
    add(289, 209, GR, 1, 1);
    add(337, 257, cur_col(fcnt + 1), 3, 3);
    lastx[209] = 385; lastx[257] = 385;
    run_frame(257, -1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending pixels, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
